avalon_mm_host: RTL and testbench

- Avalon-MM host (initiator) that drives peripheral memory slaves from a simple command stream.
- Accepts read/write commands on a valid/ready interface and issues them on the Avalon bus, honouring av_waitrequest.
- Collects pipelined read data (av_readdatavalid) into a response FIFO and returns it on a valid/ready response stream.
- Sits between a test/control engine (or CPU bridge) and any Avalon slave, including fixed-latency block-RAM adapters that tie waitrequest low.

---
 rtl/avalon_mm_host.sv | 128 ++++++++++++
 tb/tb_avalon_mm_host.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_host.sv
// Avalon-MM host: turns a valid/ready command stream into Avalon read/write
// bus operations and returns pipelined read data on a valid/ready stream.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   cmd_*             command stream (write flag, word address, write data)
//   rsp_*             read response stream, data in issue order
//   av_*              Avalon-MM host signals (waitrequest, readdatavalid in)
//   pending           reads accepted but not yet popped from rsp
//   idle              no bus op active and nothing pending
//   err_overflow      sticky: read data arrived with no reserved slot
module avalon_mm_host #(
    parameter int ADDRESSWIDTH = 8,
    parameter int MAX_PENDING  = 4,
    parameter int CNTWIDTH     = $clog2(MAX_PENDING + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESSWIDTH-1:0] cmd_address,
    input  logic [31:0]             cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic                    av_read,
    output logic                    av_write,
    output logic [ADDRESSWIDTH-1:0] av_address,
    output logic [31:0]             av_writedata,
    input  logic                    av_waitrequest,
    input  logic                    av_readdatavalid,
    input  logic [31:0]             av_readdata,
    output logic [CNTWIDTH-1:0]     pending,
    output logic                    idle,
    output logic                    err_overflow
);

    localparam int PTRW = $clog2(MAX_PENDING);
    localparam logic [CNTWIDTH-1:0] MAX_CNT = CNTWIDTH'(MAX_PENDING);
    localparam logic [CNTWIDTH-1:0] ONE = CNTWIDTH'(1);

    logic                op_active;
    logic                accept;
    logic                pop;
    logic                push;
    logic                slot_free;
    logic [31:0]         fifo_mem [MAX_PENDING];
    logic [PTRW-1:0]     wr_ptr;
    logic [PTRW-1:0]     rd_ptr;
    logic [CNTWIDTH-1:0] count;

    assign op_active = av_read | av_write;
    assign cmd_ready = (!op_active || !av_waitrequest) && (pending < MAX_CNT);
    assign accept    = cmd_valid & cmd_ready;
    assign pop       = rsp_valid & rsp_ready;

    // A read is still outstanding on the bus only if fewer responses
    // sit in the FIFO than reads have been credited.
    assign slot_free = (count != pending);
    assign push      = av_readdatavalid & slot_free;

    assign rsp_valid = (count != '0);
    assign rsp_data  = fifo_mem[rd_ptr];
    assign idle      = !op_active && (pending == '0);

    // Bus op register: loaded on accept, dropped once the slave takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            av_read      <= 1'b0;
            av_write     <= 1'b0;
            av_address   <= '0;
            av_writedata <= '0;
        end else if (accept) begin
            av_read      <= !cmd_write;
            av_write     <= cmd_write;
            av_address   <= cmd_address;
            av_writedata <= cmd_data;
        end else if (!av_waitrequest) begin
            av_read  <= 1'b0;
            av_write <= 1'b0;
        end
    end

    // Read credits: reserved at accept, released when the response leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({accept & !cmd_write, pop})
                2'b10:   pending <= pending + ONE;
                2'b01:   pending <= pending - ONE;
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= av_readdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            if (av_readdatavalid && !slot_free) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_mm_host.sv
// Self-checking bench for avalon_mm_host: behavioural slave, in-order
// command/response model and per-cycle output comparison.
module tb_avalon_mm_host;

    localparam int AW = 8;
    localparam int MP = 4;
    localparam int CW = $clog2(MP + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_address = '0;
    logic [31:0]   cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          av_read;
    logic          av_write;
    logic [AW-1:0] av_address;
    logic [31:0]   av_writedata;
    logic          av_waitrequest = 1'b0;
    logic          av_readdatavalid = 1'b0;
    logic [31:0]   av_readdata = '0;
    logic [CW-1:0] pending;
    logic          idle;
    logic          err_overflow;

    always #5 clk = ~clk;

    avalon_mm_host #(.ADDRESSWIDTH(AW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_address(cmd_address),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .av_read(av_read), .av_write(av_write),
        .av_address(av_address), .av_writedata(av_writedata),
        .av_waitrequest(av_waitrequest),
        .av_readdatavalid(av_readdatavalid), .av_readdata(av_readdata),
        .pending(pending), .idle(idle), .err_overflow(err_overflow)
    );

    typedef struct { bit wr; bit [AW-1:0] a; bit [31:0] d; } cmd_t;
    typedef struct { int due; bit [31:0] d; } rdv_t;

    cmd_t      cmd_q[$];
    cmd_t      issued_q[$];
    rdv_t      rdv_q[$];
    bit [31:0] exp_q[$];
    bit [31:0] smem[256];
    bit [31:0] mmem[256];

    int m_pend = 0;
    int m_cnt = 0;
    bit m_err = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rr_mode = 0;
    int wait_pct = 0;
    int hold = 0;
    int lat = 1;
    int gap_pct = 0;
    bit spur = 0;
    int wr_cyc = 0;
    int rd_cyc = 0;
    int nrdy_cyc = 0;
    int rsp_cnt = 0;
    bit [31:0] last_rsp = '0;
    bit        prev_wait = 0;
    bit        prev_op = 0;
    bit [63:0] prev_bus = '0;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     n, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] bus_now();
        return 64'({av_read, av_write, av_address, av_writedata});
    endfunction

    task automatic check();
        chk("pending", 64'(pending), 64'(m_pend));
        chk("pending_max", 64'(int'(pending) <= MP), 64'(1));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_cnt > 0));
        chk("idle", 64'(idle), 64'(issued_q.size() == 0 && m_pend == 0));
        chk("err_overflow", 64'(err_overflow), 64'(m_err));
        chk("op_present", 64'(av_read | av_write),
            64'(issued_q.size() != 0));
        if (prev_wait && prev_op)
            chk("stall_hold", bus_now(), prev_bus);
    endtask

    task automatic drive();
        cyc++;
        if (hold > 0 && (av_read || av_write)) begin
            av_waitrequest = 1'b1;
            hold--;
        end else begin
            av_waitrequest = ($urandom_range(99) < wait_pct);
        end
        if (rdv_q.size() != 0 && rdv_q[0].due <= cyc) begin
            av_readdatavalid = 1'b1;
            av_readdata = rdv_q[0].d;
            void'(rdv_q.pop_front());
        end else if (spur) begin
            av_readdatavalid = 1'b1;
            av_readdata = $urandom;
            spur = 0;
        end else begin
            av_readdatavalid = 1'b0;
            av_readdata = $urandom;
        end
        if (cmd_q.size() != 0 && $urandom_range(99) >= gap_pct) begin
            cmd_valid = 1'b1;
            cmd_write = cmd_q[0].wr;
            cmd_address = cmd_q[0].a;
            cmd_data = cmd_q[0].d;
        end else begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_address = AW'($urandom);
            cmd_data = $urandom;
        end
        case (rr_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            2:       rsp_ready = (cyc % 2) == 1;
            default: rsp_ready = 1'($urandom);
        endcase
    endtask

    task automatic record();
        bit   acc;
        bit   pop;
        bit   done;
        cmd_t c;
        acc  = cmd_valid && cmd_ready;
        pop  = rsp_valid && rsp_ready;
        done = (av_read || av_write) && !av_waitrequest;
        chk("cmd_ready", 64'(cmd_ready),
            64'((issued_q.size() == 0 || !av_waitrequest) && m_pend < MP));
        if (av_write) wr_cyc++;
        if (av_read) rd_cyc++;
        if (av_write && !cmd_ready) nrdy_cyc++;
        prev_wait = av_waitrequest;
        prev_op = av_read | av_write;
        prev_bus = bus_now();
        if (done) begin
            if (issued_q.size() == 0) begin
                chk("bus_op_unexpected", 64'(1), 64'(0));
            end else begin
                c = issued_q.pop_front();
                chk("bus_kind", 64'({av_read, av_write}),
                    64'({!c.wr, c.wr}));
                chk("bus_addr", 64'(av_address), 64'(c.a));
                if (c.wr) chk("bus_wdata", 64'(av_writedata), 64'(c.d));
            end
            if (av_write) smem[av_address] = av_writedata;
            else rdv_q.push_back('{cyc + lat, smem[av_address]});
        end
        if (av_readdatavalid) begin
            if (m_pend - m_cnt > 0) m_cnt++;
            else m_err = 1;
        end
        if (pop) begin
            rsp_cnt++;
            last_rsp = rsp_data;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(1), 64'(0));
            end else begin
                chk("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
            end
            m_cnt--;
            m_pend--;
        end
        if (acc) begin
            c = '{cmd_write, cmd_address, cmd_data};
            issued_q.push_back(c);
            void'(cmd_q.pop_front());
            if (c.wr) begin
                mmem[c.a] = c.d;
            end else begin
                exp_q.push_back(mmem[c.a]);
                m_pend++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check();
        drive();
        #1;
        record();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(int maxc, string n);
        int k = 0;
        while ((cmd_q.size() != 0 || issued_q.size() != 0 ||
                rdv_q.size() != 0 || exp_q.size() != 0 || m_cnt != 0)
               && k < maxc) begin
            step();
            k++;
        end
        chk({n, "_drained"}, 64'(k < maxc), 64'(1));
    endtask

    task automatic clear_model();
        issued_q.delete();
        exp_q.delete();
        rdv_q.delete();
        cmd_q.delete();
        m_pend = 0;
        m_cnt = 0;
        m_err = 0;
        prev_wait = 0;
        prev_op = 0;
        hold = 0;
        spur = 0;
    endtask

    task automatic reset_values(string n);
        chk({n, "_av_read"}, 64'(av_read), 64'(0));
        chk({n, "_av_write"}, 64'(av_write), 64'(0));
        chk({n, "_av_address"}, 64'(av_address), 64'(0));
        chk({n, "_av_writedata"}, 64'(av_writedata), 64'(0));
        chk({n, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({n, "_pending"}, 64'(pending), 64'(0));
        chk({n, "_err"}, 64'(err_overflow), 64'(0));
        chk({n, "_idle"}, 64'(idle), 64'(1));
    endtask

    initial begin
        int base;
        bit [AW-1:0] a;
        for (int i = 0; i < 256; i++) begin
            smem[i] = $urandom;
            mmem[i] = smem[i];
        end
        #1 reset = 1'b1;
        #1 reset_values("reset");
        @(negedge clk);
        reset = 1'b0;

        // single read, latency 1
        smem[8'h10] = 32'hDEADBEEF;
        mmem[8'h10] = 32'hDEADBEEF;
        rr_mode = 1;
        rd_cyc = 0;
        cmd_q.push_back('{1'b0, 8'h10, 32'h0});
        drain(20, "t1");
        chk("t1_data", 64'(last_rsp), 64'h0000_0000_DEAD_BEEF);
        chk("t1_read_cycles", 64'(rd_cyc), 64'(1));
        step();
        chk("t1_pending", 64'(pending), 64'(0));

        // write held by waitrequest for 3 cycles
        base = rsp_cnt;
        wr_cyc = 0;
        nrdy_cyc = 0;
        hold = 3;
        cmd_q.push_back('{1'b1, 8'h05, 32'h12345678});
        steps(8);
        chk("t2_write_cycles", 64'(wr_cyc), 64'(4));
        chk("t2_ready_low", 64'(nrdy_cyc), 64'(3));
        chk("t2_no_rsp", 64'(rsp_cnt), 64'(base));
        chk("t2_landed", 64'(smem[8'h05]), 64'h1234_5678);

        // six reads against four credits
        rr_mode = 0;
        base = rsp_cnt;
        for (int i = 0; i < 6; i++)
            cmd_q.push_back('{1'b0, AW'(8'h20 + i), 32'h0});
        steps(12);
        chk("t3_pending", 64'(pending), 64'(4));
        chk("t3_left", 64'(cmd_q.size()), 64'(2));
        chk("t3_ready", 64'(cmd_ready), 64'(0));
        rr_mode = 1;
        drain(60, "t3");
        chk("t3_rsp_count", 64'(rsp_cnt - base), 64'(6));

        // R/W/R to one address, latency 2, toggling rsp_ready
        rr_mode = 2;
        lat = 2;
        cmd_q.push_back('{1'b0, 8'h33, 32'h0});
        cmd_q.push_back('{1'b1, 8'h33, 32'hA5A50001});
        cmd_q.push_back('{1'b0, 8'h33, 32'h0});
        drain(60, "t4");
        chk("t4_raw", 64'(last_rsp), 64'h0000_0000_A5A5_0001);

        // randomized traffic
        rr_mode = 3;
        lat = 3;
        wait_pct = 30;
        gap_pct = 30;
        for (int i = 0; i < 200; i++) begin
            a = AW'($urandom_range(15));
            cmd_q.push_back('{1'($urandom), a, $urandom});
        end
        drain(5000, "t5");
        wait_pct = 0;
        gap_pct = 0;
        lat = 1;

        // spurious readdatavalid
        spur = 1;
        steps(2);
        chk("t6_err", 64'(err_overflow), 64'(1));
        chk("t6_rsp_valid", 64'(rsp_valid), 64'(0));
        steps(4);

        // reset with two reads outstanding and av_read stalled
        rr_mode = 0;
        lat = 10;
        for (int i = 0; i < 3; i++)
            cmd_q.push_back('{1'b0, AW'(8'h40 + i), 32'h0});
        steps(2);
        wait_pct = 100;
        step();
        chk("t7_av_read", 64'(av_read), 64'(1));
        chk("t7_pending", 64'(pending), 64'(2));
        @(posedge clk);
        #2 reset = 1'b1;
        #1 reset_values("t7_reset");
        clear_model();
        wait_pct = 0;
        steps(2);
        reset = 1'b0;
        #1;
        chk("t7_idle", 64'(idle), 64'(1));
        chk("t7_cmd_ready", 64'(cmd_ready), 64'(1));
        spur = 1;
        steps(2);
        chk("t7_late_err", 64'(err_overflow), 64'(1));
        steps(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
